// File: rtl/serial_frame_pkg.sv
// Shared types, constants and helpers for the serial frame receiver.
package serial_frame_pkg;

  localparam int unsigned MAX_DATA_W   = 32;
  localparam int unsigned CNT_W        = 8;
  localparam logic [7:0]  SYNC_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  // Even-parity bit of a word: 1 when the word holds an odd number of ones.
  function automatic logic parity_even(input logic [MAX_DATA_W-1:0] bits);
    return ^bits;
  endfunction

endpackage : serial_frame_pkg

// File: rtl/serial_frame_rx_if.sv
// Serial input and parallel result bundle of the frame receiver.
interface serial_frame_rx_if
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_W = 8
);

  logic              sin;
  logic              ben;
  logic [DATA_W-1:0] dout;
  logic              dvalid;
  logic              perr;
  logic [CNT_W-1:0]  frame_cnt;

  modport master (
    output sin, ben,
    input  dout, dvalid, perr, frame_cnt
  );

  modport slave (
    input  sin, ben,
    output dout, dvalid, perr, frame_cnt
  );

endinterface : serial_frame_rx_if

// File: rtl/sync_detect.sv
// Sliding sync-word window with fill tracking; flags a match on the bit that completes it.
module sync_detect
  import serial_frame_pkg::*;
#(
  parameter int unsigned      SYNC_W = 8,
  parameter logic [SYNC_W-1:0] SYNC  = SYNC_W'(SYNC_DEFAULT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic ben_i,
  input  logic sin_i,
  output logic hit_c_o
);

  // Only the newest SYNC_W-1 bits ever reach the comparator together with sin_i,
  // so the oldest window bit is never stored.
  localparam int unsigned WIN_W  = SYNC_W - 1;
  localparam int unsigned FILL_W = $clog2(SYNC_W + 1);

  logic [WIN_W-1:0]  win_q,  win_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  // Window and fill counter update on enabled edges only.
  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (ben_i) begin
      if (clr_i) begin
        win_d  = '0;
        fill_d = '0;
      end else begin
        win_d = WIN_W'({win_q, sin_i});
        if (fill_q != FILL_W'(SYNC_W)) begin
          fill_d = fill_q + FILL_W'(1);
        end
      end
    end
  end

  // Window state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end

  // Match on the edge that shifts in the last sync bit.
  always_comb begin
    hit_c_o = ben_i && !clr_i
              && (fill_q >= FILL_W'(SYNC_W - 1))
              && ({win_q, sin_i} == SYNC);
  end

endmodule : sync_detect

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: sync hunt, data deserialiser, even-parity check, good-frame counter.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int unsigned       SYNC_W = 8,
  parameter logic [SYNC_W-1:0] SYNC   = SYNC_W'(SYNC_DEFAULT),
  parameter int unsigned       DATA_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  serial_frame_rx_if.slave bus
);

  localparam int unsigned BCNT_W = $clog2(DATA_W) + 1;

  state_e            state_q, state_d;
  logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dvalid_q, dvalid_d;
  logic              perr_q, perr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sync_clr_c;
  logic              sync_hit_c;
  logic              par_c;

  // Window is held empty outside HUNT so a new hunt never reuses old bits.
  assign sync_clr_c = (state_q != ST_HUNT);

  sync_detect #(
    .SYNC_W (SYNC_W),
    .SYNC   (SYNC)
  ) u_sync_detect (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (sync_clr_c),
    .ben_i   (bus.ben),
    .sin_i   (bus.sin),
    .hit_c_o (sync_hit_c)
  );

  // Overall parity of the data word plus the incoming parity bit.
  assign par_c = parity_even(MAX_DATA_W'(data_q)) ^ bus.sin;

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    dout_d    = dout_q;
    dvalid_d  = 1'b0;
    perr_d    = 1'b0;
    cnt_d     = cnt_q;
    if (bus.ben) begin
      unique case (state_q)
        ST_HUNT: begin
          if (sync_hit_c) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          data_d    = DATA_W'({data_q, bus.sin});
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
          if (bit_cnt_q == BCNT_W'(DATA_W - 1)) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (!par_c) begin
            dout_d   = data_q;
            dvalid_d = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
          end else begin
            perr_d = 1'b1;
          end
          state_d = ST_HUNT;
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_HUNT;
      bit_cnt_q <= '0;
      data_q    <= '0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      perr_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      perr_q    <= perr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dvalid    = dvalid_q;
  assign bus.perr      = perr_q;
  assign bus.frame_cnt = cnt_q;

endmodule : serial_frame_rx
